// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer: borrows the shared ALU in add mode to form the
// low WIDTH bits of op_a*op_b, one multiplier bit per ITER cycle.
module alu_mul_sequencer #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned CNT_W  = 7,
    parameter logic [2:0]  ADD_OP = 3'b010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_product;

    logic             w_iter;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_last;

    assign w_iter        = (r_state == S_ITER);
    assign w_mplier_next = r_mplier >> 1;
    // Stop early once no multiplier bits remain; the count bound covers the MSB case.
    assign w_last        = (w_mplier_next == '0) || (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        if (op_b == '0) begin
                            r_product <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_acc    <= alu_result;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_product <= alu_result;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (r_state == S_ITER) || (r_state == S_DONE);
        done      = (r_state == S_DONE);
        product   = r_product;
        alu_req   = w_iter;
        alu_a     = w_iter ? r_acc : '0;
        alu_b     = (w_iter && r_mplier[0]) ? r_mcand : '0;
        alu_cntrl = w_iter ? ADD_OP : 3'b000;
    end

endmodule
